// File: rtl/ssemi_adc_decimator_cfg_loader_pkg.sv
// Shared types and constants for the decimator configuration loader.
// The optional checksum (macro SSEMI_CFG_LOADER_CHECKSUM_EN) lives in the top.
package ssemi_adc_decimator_cfg_pkg;

    localparam int DEF_TABLE_DEPTH    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_CFG_ADDR_WIDTH = 8;
    localparam int DEF_CFG_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE    = 2'd0;
    localparam err_t ERR_TIMEOUT = 2'd1;
    localparam err_t ERR_BAD_LEN = 2'd2;
    localparam err_t ERR_ABORT   = 2'd3;

endpackage

// File: rtl/ssemi_adc_decimator_cfg_loader_if.sv
// Valid/ready configuration port towards the decimator (address + data).
interface ssemi_adc_decimator_cfg_loader_if
    import ssemi_adc_decimator_cfg_pkg::*;
#(
    parameter int AW = DEF_CFG_ADDR_WIDTH,
    parameter int DW = DEF_CFG_DATA_WIDTH
);
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/ssemi_cfg_table.sv
// Entry table: DEPTH rows of (addr, data), synchronous write, registered read.
// The read register only updates when i_re is high so the issued entry holds
// still while the handshake is pending.
module ssemi_cfg_table
    import ssemi_adc_decimator_cfg_pkg::*;
#(
    parameter int DEPTH = DEF_TABLE_DEPTH,
    parameter int AW    = DEF_CFG_ADDR_WIDTH,
    parameter int DW    = DEF_CFG_DATA_WIDTH,
    localparam int IW   = $clog2(DEPTH)
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_re,
    input  logic [IW-1:0] i_rd_idx,
    output logic [AW-1:0] o_rd_addr,
    output logic [DW-1:0] o_rd_data
);
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] row_we;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_we
            assign row_we[gi] = i_we && (i_wr_idx == IW'(gi));
        end
    endgenerate

    // Row storage: cleared on reset, written when the row is selected
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (row_we[i]) begin
                    addr_mem[i] <= i_wr_addr;
                    data_mem[i] <= i_wr_data;
                end
            end
        end
    end

    // Registered read port, updated only on request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else if (i_re) begin
            o_rd_addr <= addr_mem[i_rd_idx];
            o_rd_data <= data_mem[i_rd_idx];
        end
    end

endmodule

// File: rtl/ssemi_adc_decimator_cfg_loader.sv
// Configuration loader: issues a pre-loaded (addr, data) table over the
// decimator config handshake with timeout, abort and progress reporting.
// Optional running checksum of accepted data: SSEMI_CFG_LOADER_CHECKSUM_EN.
module ssemi_adc_decimator_cfg_loader
    import ssemi_adc_decimator_cfg_pkg::*;
#(
    parameter int TABLE_DEPTH    = DEF_TABLE_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CFG_ADDR_WIDTH = DEF_CFG_ADDR_WIDTH,
    parameter int CFG_DATA_WIDTH = DEF_CFG_DATA_WIDTH,
    localparam int IW            = $clog2(TABLE_DEPTH)
)(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_tbl_we,
    input  logic [IW-1:0]             i_tbl_idx,
    input  logic [CFG_ADDR_WIDTH-1:0] i_tbl_addr,
    input  logic [CFG_DATA_WIDTH-1:0] i_tbl_data,
    input  logic [IW:0]               i_num_entries,
    input  logic                      i_start,
    input  logic                      i_abort,
    ssemi_adc_decimator_cfg_loader_if.master cfg,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [1:0]                o_error_type,
    output logic [IW:0]               o_progress,
    output logic [CFG_DATA_WIDTH-1:0] o_checksum
);
    localparam int              TW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IW:0]     DEPTH_LIM = (IW+1)'(TABLE_DEPTH);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t                    state_reg;
    logic [IW-1:0]             idx_reg;
    logic [IW:0]               num_reg;
    logic [IW:0]               progress_reg;
    logic [TW-1:0]             tmo_cnt_reg;
    logic                      valid_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic                      error_reg;
    err_t                      err_type_reg;
    logic [CFG_ADDR_WIDTH-1:0] tbl_rd_addr;
    logic [CFG_DATA_WIDTH-1:0] tbl_rd_data;
    logic                      accept;
    logic                      start_ok;

    assign accept   = valid_reg && cfg.ready;
    assign start_ok = (state_reg == ST_IDLE) && i_start;

    // Writes are only honoured while idle; the fetch reads one cycle after
    // start, so a write issued alongside start is already visible.
    ssemi_cfg_table #(
        .DEPTH (TABLE_DEPTH),
        .AW    (CFG_ADDR_WIDTH),
        .DW    (CFG_DATA_WIDTH)
    ) u_table (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (i_tbl_we && !busy_reg),
        .i_wr_idx  (i_tbl_idx),
        .i_wr_addr (i_tbl_addr),
        .i_wr_data (i_tbl_data),
        .i_re      (state_reg == ST_FETCH),
        .i_rd_idx  (idx_reg),
        .o_rd_addr (tbl_rd_addr),
        .o_rd_data (tbl_rd_data)
    );

    // Sequencer: start checks, fetch/issue loop, timeout, abort, status
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            num_reg      <= '0;
            progress_reg <= '0;
            tmo_cnt_reg  <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            err_type_reg <= ERR_NONE;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        error_reg    <= 1'b0;
                        err_type_reg <= ERR_NONE;
                        progress_reg <= '0;
                        idx_reg      <= '0;
                        num_reg      <= i_num_entries;
                        busy_reg     <= 1'b1;
                        if (i_num_entries == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else if (i_num_entries > DEPTH_LIM) begin
                            state_reg    <= ST_ERROR;
                            error_reg    <= 1'b1;
                            err_type_reg <= ERR_BAD_LEN;
                        end else begin
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_abort) begin
                        state_reg    <= ST_ERROR;
                        error_reg    <= 1'b1;
                        err_type_reg <= ERR_ABORT;
                    end else begin
                        valid_reg   <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // An accepted transfer counts even if abort arrives with it
                    if (accept) begin
                        progress_reg <= progress_reg + 1'b1;
                        idx_reg      <= idx_reg + 1'b1;
                        valid_reg    <= 1'b0;
                    end
                    if (i_abort) begin
                        valid_reg    <= 1'b0;
                        state_reg    <= ST_ERROR;
                        error_reg    <= 1'b1;
                        err_type_reg <= ERR_ABORT;
                    end else if (accept) begin
                        if (progress_reg + 1'b1 == num_reg) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_FETCH;
                        end
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        valid_reg    <= 1'b0;
                        state_reg    <= ST_ERROR;
                        error_reg    <= 1'b1;
                        err_type_reg <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_ERROR: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SSEMI_CFG_LOADER_CHECKSUM_EN
    logic [CFG_DATA_WIDTH-1:0] checksum_reg;

    // Wrapping sum of accepted data, restarted by each accepted start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            checksum_reg <= '0;
        end else if (start_ok) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= checksum_reg + tbl_rd_data;
        end
    end

    assign o_checksum = checksum_reg;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign o_checksum      = '0;
`endif

    assign cfg.valid    = valid_reg;
    assign cfg.addr     = tbl_rd_addr;
    assign cfg.data     = tbl_rd_data;
    assign o_busy       = busy_reg;
    assign o_done       = done_reg;
    assign o_error      = error_reg;
    assign o_error_type = err_type_reg;
    assign o_progress   = progress_reg;

endmodule

// File: tb/tb_ssemi_adc_decimator_cfg_loader.sv
// Scoreboard bench for the configuration loader: the stimulus side queues
// the transfers the table should produce, a negedge monitor pops and compares
// every handshake, and sequence results are compared against a table model.
module tb_ssemi_adc_decimator_cfg_loader;
    localparam int DEPTH = 16;
    localparam int TMO   = 16;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tbl_we;
    logic [IW-1:0] tbl_idx;
    logic [AW-1:0] tbl_addr;
    logic [DW-1:0] tbl_data;
    logic [IW:0]   num_entries;
    logic          start;
    logic          abort_s;
    logic          busy, done, error;
    logic [1:0]    error_type;
    logic [IW:0]   progress;
    logic [DW-1:0] checksum;

    ssemi_adc_decimator_cfg_loader_if #(.AW(AW), .DW(DW)) cfg_bus ();

    always #5 clk = ~clk;

    ssemi_adc_decimator_cfg_loader #(
        .TABLE_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .CFG_ADDR_WIDTH (AW),
        .CFG_DATA_WIDTH (DW)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_tbl_we      (tbl_we),
        .i_tbl_idx     (tbl_idx),
        .i_tbl_addr    (tbl_addr),
        .i_tbl_data    (tbl_data),
        .i_num_entries (num_entries),
        .i_start       (start),
        .i_abort       (abort_s),
        .cfg           (cfg_bus.master),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_error_type  (error_type),
        .o_progress    (progress),
        .o_checksum    (checksum)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xfer_t;

    xfer_t         exp_q[$];
    logic [AW-1:0] m_addr [DEPTH];
    logic [DW-1:0] m_data [DEPTH];

    int tests = 0;
    int fails = 0;
    int acc_cnt, done_cnt, valid_cyc;
    int ready_mode, stall_idx, stall_left;
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: score every handshake against the queue, check hold-under-stall
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_bus.valid) valid_cyc++;
            if (done) done_cnt++;
            if (prev_stall && cfg_bus.valid) begin
                check("hold_addr", 64'(cfg_bus.addr), 64'(prev_addr));
                check("hold_data", 64'(cfg_bus.data), 64'(prev_data));
            end
            if (cfg_bus.valid && cfg_bus.ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL xfer_unexpected: got addr 0x%0h data 0x%0h, required no transfer",
                             cfg_bus.addr, cfg_bus.data);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    $display("[TB] xfer %0d addr 0x%0h data 0x%0h", acc_cnt, cfg_bus.addr, cfg_bus.data);
                    check("xfer_addr", 64'(cfg_bus.addr), 64'(e.a));
                    check("xfer_data", 64'(cfg_bus.data), 64'(e.d));
                end
            end
            prev_stall = cfg_bus.valid && !cfg_bus.ready;
            prev_addr  = cfg_bus.addr;
            prev_data  = cfg_bus.data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Ready driver: always / random / never / stall a chosen entry
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: cfg_bus.ready = 1'b1;
            1: cfg_bus.ready = ($urandom_range(0, 3) != 0);
            2: cfg_bus.ready = 1'b0;
            default: begin
                if (cfg_bus.valid && acc_cnt == stall_idx && stall_left > 0) begin
                    cfg_bus.ready = 1'b0;
                    stall_left--;
                end else begin
                    cfg_bus.ready = 1'b1;
                end
            end
        endcase
    end

    task automatic write_entry(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_idx  = IW'(idx);
        tbl_addr = a;
        tbl_data = d;
        m_addr[idx] = a;
        m_data[idx] = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic clear_counts();
        acc_cnt   = 0;
        done_cnt  = 0;
        valid_cyc = 0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s_idle_wait: busy still 1 after %0d cycles, required 0", tag, k);
        end
        @(negedge clk);
    endtask

    // mode 0: expect normal completion / length outcome; mode 1: expect timeout
    task automatic run_seq(input int n, input int mode, input bit wr_same, input bit wr_busy, input string tag);
        logic [DW-1:0] sum;
        int            exp_type, exp_prog, exp_done;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            issues;
        sum    = '0;
        issues = (n >= 1 && n <= DEPTH);
        @(negedge clk);
        clear_counts();
        start       = 1'b1;
        num_entries = (IW+1)'(n);
        if (wr_same) begin
            wa = AW'($urandom);
            wd = $urandom;
            tbl_we = 1'b1; tbl_idx = '0; tbl_addr = wa; tbl_data = wd;
            m_addr[0] = wa;
            m_data[0] = wd;
        end
        if (n == 0) begin
            exp_type = 0; exp_prog = 0; exp_done = 1;
        end else if (n > DEPTH) begin
            exp_type = 2; exp_prog = 0; exp_done = 0;
        end else if (mode == 1) begin
            exp_type = 1; exp_prog = 0; exp_done = 0;
        end else begin
            exp_type = 0; exp_prog = n; exp_done = 1;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({m_addr[i], m_data[i]});
                sum += m_data[i];
            end
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        tbl_we      = 1'b0;
        num_entries = (IW+1)'($urandom);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_valid_lat1"}, 64'(cfg_bus.valid), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid_lat2"}, 64'(cfg_bus.valid), 64'(issues));
        if (wr_busy && issues) begin
            tbl_we = 1'b1; tbl_idx = '0; tbl_addr = AW'($urandom); tbl_data = $urandom;
            @(posedge clk);
            #1;
            tbl_we = 1'b0;
        end
        wait_idle(tag);
        check({tag, "_err_type"}, 64'(error_type), 64'(exp_type));
        check({tag, "_error"}, 64'(error), 64'(exp_type != 0));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(exp_done));
        check({tag, "_progress"}, 64'(progress), 64'(exp_prog));
        check({tag, "_accepted"}, 64'(acc_cnt), 64'(exp_prog));
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
`ifdef SSEMI_CFG_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, 64'(checksum), 64'(sum));
`else
        check({tag, "_checksum"}, 64'(checksum), 64'd0);
`endif
        if (mode == 1) check({tag, "_valid_cycles"}, 64'(valid_cyc), 64'(TMO));
        if (!issues) check({tag, "_no_valid"}, 64'(valid_cyc), 64'd0);
        exp_q.delete();
        $display("[TB] seq %s n=%0d type=%0d progress=%0d", tag, n, error_type, progress);
    endtask

    initial begin
        int n;
        bit found;
        logic [DW-1:0] sum2;
        rst_n = 1'b0;
        tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
        num_entries = '0; start = 1'b0; abort_s = 1'b0;
        cfg_bus.ready = 1'b0;
        ready_mode = 0; stall_idx = 0; stall_left = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        clear_counts();
        for (int i = 0; i < DEPTH; i++) begin m_addr[i] = '0; m_data[i] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_type", 64'(error_type), 64'd0);
        check("rst_progress", 64'(progress), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_valid", 64'(cfg_bus.valid), 64'd0);
        rst_n = 1'b1;

        // Normal sequence
        write_entry(0, 8'h01, 32'h0000_0040);
        write_entry(1, 8'h02, 32'h0000_1234);
        write_entry(2, 8'h10, 32'hDEAD_BEEF);
        ready_mode = 0;
        run_seq(3, 0, 1'b0, 1'b0, "normal");

        // Backpressure on entry 1 for 5 cycles
        ready_mode = 3; stall_idx = 1; stall_left = 5;
        run_seq(3, 0, 1'b0, 1'b0, "stall");
        check("stall_consumed", 64'(stall_left), 64'd0);

        // Timeout with ready held low
        ready_mode = 2;
        run_seq(3, 1, 1'b0, 1'b0, "timeout");

        // Length boundaries
        ready_mode = 0;
        run_seq(0, 0, 1'b0, 1'b0, "len0");
        run_seq(DEPTH + 1, 0, 1'b0, 1'b0, "len17");
        run_seq(DEPTH, 0, 1'b0, 1'b0, "len16");

        // Abort coinciding with acceptance of entry 1
        @(negedge clk);
        clear_counts();
        exp_q.push_back({m_addr[0], m_data[0]});
        exp_q.push_back({m_addr[1], m_data[1]});
        sum2 = m_data[0] + m_data[1];
        start = 1'b1; num_entries = 5'd3;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (cfg_bus.valid && progress == 5'd1) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_sync_found", 64'(found), 64'd1);
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        check("abort_valid_drop", 64'(cfg_bus.valid), 64'd0);
        wait_idle("abort");
        check("abort_type", 64'(error_type), 64'd3);
        check("abort_error", 64'(error), 64'd1);
        check("abort_progress", 64'(progress), 64'd2);
        check("abort_accepted", 64'(acc_cnt), 64'd2);
        check("abort_done_pulses", 64'(done_cnt), 64'd0);
        check("abort_queue_left", 64'(exp_q.size()), 64'd0);
`ifdef SSEMI_CFG_LOADER_CHECKSUM_EN
        check("abort_checksum", 64'(checksum), 64'(sum2));
`else
        check("abort_checksum", 64'(checksum), 64'd0);
`endif
        $display("[TB] seq abort type=%0d progress=%0d", error_type, progress);

        // Abort while idle has no effect
        run_seq(2, 0, 1'b0, 1'b0, "pre_idle_abort");
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", 64'(busy), 64'd0);
        check("idle_abort_error", 64'(error), 64'd0);
        check("idle_abort_progress", 64'(progress), 64'd2);

        // Randomised table contents, lengths and backpressure
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 4; w++)
                write_entry($urandom_range(0, DEPTH - 1), AW'($urandom), $urandom);
            n = $urandom_range(1, DEPTH);
            ready_mode = 1;
            run_seq(n, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        // Reset in the middle of a transfer
        ready_mode = 2;
        @(negedge clk);
        start = 1'b1; num_entries = 5'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_valid", 64'(cfg_bus.valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(cfg_bus.valid), 64'd0);
        check("mid_rst_addr", 64'(cfg_bus.addr), 64'd0);
        check("mid_rst_data", 64'(cfg_bus.data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_progress", 64'(progress), 64'd0);
        check("mid_rst_error", 64'(error), 64'd0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin m_addr[i] = '0; m_data[i] = '0; end
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(2, 0, 1'b0, 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
